// File: rtl/matrix_scan_capture_if.sv
// matrix_scan_capture_if: scan-line inputs and captured-frame outputs of the matrix capture stage
interface matrix_scan_capture_if #(parameter int gs = 8);
   logic               e_cap_i;
   logic               scan_vld_i;
   logic [gs-1:0]      row_val_i;
   logic [gs-1:0]      col_val_i;
   logic [gs*gs-1:0]   matrix_o;
   logic               d_cap_o;
   logic               busy_o;
   logic               err_o;
   logic               to_o;
   modport slave (input e_cap_i, scan_vld_i, row_val_i, col_val_i,
                  output matrix_o, d_cap_o, busy_o, err_o, to_o);
   modport master (output e_cap_i, scan_vld_i, row_val_i, col_val_i,
                   input matrix_o, d_cap_o, busy_o, err_o, to_o);
endinterface

// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: rebuilds a gs x gs frame from row/column scan lines; CAP_TIMEOUT_EN adds an idle timeout
module matrix_scan_capture #(
   parameter int gs     = 8,
   parameter int to_cyc = 255
) (
   input logic                   clk_i,
   input logic                   rst_n,
   matrix_scan_capture_if.slave  cap
);
   localparam int iw = gs > 1 ? $clog2(gs) : 1;
   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
   state_t             state_q, state_d;
   logic [gs*gs-1:0]   shadow_q, shadow_d;
   logic [gs*gs-1:0]   matrix_q, matrix_d;
   logic [gs-1:0]      seen_q, seen_d;
   logic               err_q, err_d;
   logic [iw-1:0]      idx;
   logic               row_ok, accept, tmo;
   // one-hot row select to binary index; only meaningful when row_ok
   always_comb begin
      idx = '0;
      for (int r = 0; r < gs; r++)
         if (cap.row_val_i[r]) idx = iw'(r);
   end
   assign row_ok = $onehot(cap.row_val_i);
   assign accept = (state_q == CAPTURE) && cap.scan_vld_i && row_ok;
`ifdef CAP_TIMEOUT_EN
   localparam int cw = $clog2(to_cyc + 1);
   logic [cw-1:0] cnt_q, cnt_d;
   assign tmo = (state_q == CAPTURE) && (cnt_q == cw'(to_cyc));
   // idle counter: cleared outside CAPTURE and on every accepted row
   always_comb cnt_d = (state_q != CAPTURE || accept) ? '0 : cnt_q + cw'(1);
   // idle counter register
   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
`else
   assign tmo = 1'b0;
`endif
   // next state, shadow merge and frame publish; the closing row is merged before publishing
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      seen_d   = seen_q;
      err_d    = err_q;
      matrix_d = matrix_q;
      case (state_q)
         IDLE: if (cap.e_cap_i) begin
            shadow_d = '0;
            seen_d   = '0;
            err_d    = 1'b0;
            state_d  = CAPTURE;
         end
         CAPTURE: if (tmo) state_d = IDLE;
         else begin
            if (accept) begin
               shadow_d[idx*gs +: gs] = cap.col_val_i;
               seen_d[idx]            = 1'b1;
            end
            if (cap.scan_vld_i && !row_ok) err_d = 1'b1;
            if (&seen_d) begin
               matrix_d = shadow_d;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and data registers
   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         matrix_q <= '0;
         seen_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         matrix_q <= matrix_d;
         seen_q   <= seen_d;
         err_q    <= err_d;
      end
   assign cap.matrix_o = matrix_q;
   assign cap.d_cap_o  = state_q == DONE;
   assign cap.busy_o   = state_q == CAPTURE;
   assign cap.err_o    = err_q;
   assign cap.to_o     = tmo;
endmodule

// File: tb/tb_matrix_scan_capture.sv
// tb_matrix_scan_capture: randomized and directed frames checked against a frame-level reference model
module tb_matrix_scan_capture;
   localparam int gs     = 8;
   localparam int to_cyc = 4;
   logic clk_i = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk_i = ~clk_i;
   matrix_scan_capture_if #(.gs(gs)) bus ();
   matrix_scan_capture #(.gs(gs), .to_cyc(to_cyc)) dut (.clk_i(clk_i), .rst_n(rst_n), .cap(bus.slave));
   // reference model: capturing flag, rows collected so far, published frame
   bit          m_cap, m_done, m_err;
   logic [gs-1:0] m_rows [gs];
   bit          m_have [gs];
   logic [63:0] m_mat;
   int          m_idle;
   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic bit m_tmo();
`ifdef CAP_TIMEOUT_EN
      return m_cap && m_idle == to_cyc;
`else
      return 1'b0;
`endif
   endfunction
   function automatic int n_have();
      int n = 0;
      for (int r = 0; r < gs; r++) n += int'(m_have[r]);
      return n;
   endfunction
   task automatic model_reset();
      m_cap = 0; m_done = 0; m_err = 0; m_mat = '0; m_idle = 0;
      for (int r = 0; r < gs; r++) begin m_rows[r] = '0; m_have[r] = 0; end
   endtask
   task automatic model_step(bit e, bit vld, logic [gs-1:0] row, logic [gs-1:0] col);
      int hot = $countones(row);
      if (m_done) m_done = 0;
      else if (!m_cap) begin
         if (e) begin
            m_cap = 1; m_err = 0; m_idle = 0;
            for (int r = 0; r < gs; r++) begin m_rows[r] = '0; m_have[r] = 0; end
         end
      end else if (m_tmo()) m_cap = 0;
      else begin
         if (vld && hot == 1) begin
            for (int r = 0; r < gs; r++) if (row[r]) begin m_rows[r] = col; m_have[r] = 1; end
            m_idle = 0;
         end else m_idle++;
         if (vld && hot != 1) m_err = 1;
         if (n_have() == gs) begin
            for (int r = 0; r < gs; r++) m_mat[r*gs +: gs] = m_rows[r];
            m_cap = 0; m_done = 1;
         end
      end
   endtask
   task automatic check_all();
      check("matrix", bus.matrix_o, m_mat);
      check("d_cap", 64'(bus.d_cap_o), 64'(m_done));
      check("busy", 64'(bus.busy_o), 64'(m_cap));
      check("err", 64'(bus.err_o), 64'(m_err));
      check("to", 64'(bus.to_o), 64'(m_tmo()));
   endtask
   task automatic cyc(bit e, bit vld, logic [gs-1:0] row, logic [gs-1:0] col);
      bus.e_cap_i = e; bus.scan_vld_i = vld; bus.row_val_i = row; bus.col_val_i = col;
      @(posedge clk_i);
      model_step(e, vld, row, col);
      @(negedge clk_i);
      check_all();
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) begin @(negedge clk_i); check_all(); end
      rst_n = 1'b1;
   endtask
   task automatic row(int r, logic [gs-1:0] col);
      cyc(0, 1, gs'(1) << r, col);
   endtask
   initial begin
      logic [gs-1:0] one;
      int perm [gs];
      bus.e_cap_i = 0; bus.scan_vld_i = 0; bus.row_val_i = '0; bus.col_val_i = '0;
      @(negedge clk_i);
      do_reset();
      cyc(0, 0, '0, '0);
      for (int r = 0; r < gs; r++) row(r, 8'hFF);
      check("idle_scan_ignored", bus.matrix_o, 64'h0);
      cyc(1, 0, '0, '0);
      for (int r = 0; r < gs; r++) row(r, 8'h01 << r);
      check("diag_dcap", 64'(bus.d_cap_o), 64'h1);
      check("diag_busy_in_done", 64'(bus.busy_o), 64'h0);
      cyc(0, 0, '0, '0);
      check("diag_matrix", bus.matrix_o, 64'h8040201008040201);
      cyc(1, 0, '0, '0);
      for (int r = gs - 1; r >= 0; r--) begin
         if (r == 3) row(3, 8'hAA);
         row(r, r == 3 ? 8'h55 : 8'h10);
      end
      cyc(0, 0, '0, '0);
      check("dup_row3", bus.matrix_o[3*gs +: gs], 64'h55);
      cyc(1, 0, '0, '0);
      row(0, 8'h11);
      cyc(0, 1, 8'h00, 8'hFF);
      cyc(0, 1, 8'h03, 8'hFF);
      check("err_set", 64'(bus.err_o), 64'h1);
      for (int r = 1; r < gs; r++) row(r, 8'h22);
      cyc(0, 0, '0, '0);
      check("err_sticky", 64'(bus.err_o), 64'h1);
      check("multihot_no_write", bus.matrix_o[gs +: gs], 64'h22);
      cyc(1, 0, '0, '0);
      check("err_cleared", 64'(bus.err_o), 64'h0);
      row(0, 8'h5A);
      do_reset();
      check("rst_matrix", bus.matrix_o, 64'h0);
      cyc(1, 0, '0, '0);
      for (int r = 0; r < gs; r++) row(r, 8'hC0 | gs'(r));
      cyc(0, 0, '0, '0);
      check("post_rst_frame", bus.matrix_o, 64'hC7C6C5C4C3C2C1C0);
      cyc(1, 0, '0, '0);
      for (int r = 0; r < 6; r++) row(r, 8'h3C);
      repeat (to_cyc + 2) cyc(0, 0, '0, '0);
`ifdef CAP_TIMEOUT_EN
      check("tmo_idle", 64'(bus.busy_o), 64'h0);
`else
      check("no_tmo_busy", 64'(bus.busy_o), 64'h1);
`endif
      check("tmo_keep_matrix", bus.matrix_o, 64'hC7C6C5C4C3C2C1C0);
      row(6, 8'h3C);
      row(7, 8'h3C);
      cyc(0, 0, '0, '0);
      for (int f = 0; f < 40; f++) begin
         for (int r = 0; r < gs; r++) perm[r] = r;
         for (int r = gs - 1; r > 0; r--) begin
            int j = $urandom_range(r, 0);
            int t = perm[r]; perm[r] = perm[j]; perm[j] = t;
         end
         cyc(1, $urandom_range(1, 0), gs'($urandom), gs'($urandom));
         for (int r = 0; r < gs; r++) begin
            case ($urandom_range(5, 0))
               0: cyc(0, 1, gs'($urandom), gs'($urandom));
               1: cyc(1, 0, gs'($urandom), gs'($urandom));
               2: row($urandom_range(gs - 1, 0), gs'($urandom));
               default: ;
            endcase
            one = gs'($urandom);
            row(perm[r], one);
         end
         repeat ($urandom_range(2, 0)) cyc($urandom_range(1, 0), 1, gs'($urandom), gs'($urandom));
         cyc(0, 0, '0, '0);
         cyc(0, 0, '0, '0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
